fpu_sched: RTL and testbench
============================

FPU_SCHED -- requirements
Module: fpu_sched

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing one FPU pipeline (2..8).
REQ-002 Parameter FW, default 23: fraction width.
REQ-003 Parameter EW, default 8: exponent width.
REQ-004 Parameter LAT, default 3: fixed FPU pipeline latency in cycles, fpu_valid_o to fpu_result_i (1..8).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid_i  input  NREQ  per-requester operation valid.
REQ-008 req_ready_o  output  NREQ  per-requester grant; one-hot or zero.
REQ-009 req_opa_i, req_opb_i, req_opc_i  input  NREQ x (EW+FW+1)  per-requester operands.
REQ-010 req_op_i  input  NREQ x 4  per-requester op code: bit3 sub, bit2 negate product, bit1 use adder, bit0 use multiplier.
REQ-011 flush_i  input  1  discard all in-flight operations.
REQ-012 fpu_valid_o  output  1  issue strobe to the FPU pipeline.
REQ-013 fpu_opa_o, fpu_opb_o, fpu_opc_o  output  EW+FW+1 each  issued operands.
REQ-014 fpu_op_o  output  4  issued op code.
REQ-015 fpu_result_i  input  EW+FW+1  FPU result, valid exactly LAT cycles after the matching fpu_valid_o.
REQ-016 fpu_flags_i  input  5  IEEE exception flags {NV,DZ,OF,UF,NX}, aligned with fpu_result_i.
REQ-017 rsp_valid_o  output  NREQ  one-hot response strobe to the owning requester.
REQ-018 rsp_result_o, rsp_flags_o, rsp_err_o  output  EW+FW+1, 5, 1  response data shared by all requesters.
REQ-019 idle_o  output  1  high when the block is in IDLE and no tag is in flight.

Function
REQ-020 A handshake occurs on requester i when req_valid_i[i] and req_ready_o[i] are both high in the same cycle; at most one grant per cycle.
REQ-021 Arbitration is round-robin: the search starts at the index after the last granted requester; after reset the pointer is 0 (requester 0 has highest priority).
REQ-022 req_ready_o is combinational from req_valid_i, the state and the pointer; a request without valid is never granted.
REQ-023 On a handshake at cycle t, fpu_valid_o and the operand/op outputs are registered and present at t+1 for exactly one cycle.
REQ-024 A tag {valid, requester id, err} enters a LAT+1 stage shift register with the issue; the tag emerging at t+1+LAT is paired with fpu_result_i/fpu_flags_i.
REQ-025 Responses are registered: rsp_valid_o[id] pulses at t+2+LAT with rsp_result_o/rsp_flags_o captured; requesters cannot backpressure responses.
REQ-026 Throughput: one issue per cycle sustained; back-to-back grants to different or the same requester are legal.
REQ-027 FSM states: IDLE (no tag in flight), RUN (at least one tag in flight), DRAIN (flush in progress).
REQ-028 IDLE->RUN on a handshake; RUN->IDLE when the last tag retires with no new handshake; any state->DRAIN on flush_i.
REQ-029 In DRAIN: req_ready_o = 0, all tag valid bits clear on the flush edge, a counter runs LAT+1 cycles, then goes to IDLE; results arriving during DRAIN produce no rsp_valid_o.
REQ-030 flush_i asserted during DRAIN restarts the drain counter.
REQ-031 A handshake and flush_i in the same cycle: flush wins; no grant is given (ready forced 0 combinationally by flush_i).
REQ-032 When no response is valid, rsp_result_o, rsp_flags_o and rsp_err_o hold their last values; rsp_valid_o = 0.

Reset
REQ-033 On rst_n low, asynchronously: state = IDLE, pointer = 0, all tag valid bits = 0, fpu_valid_o = 0, rsp_valid_o = 0, all data outputs = 0, idle_o = 1.
REQ-034 Reset mid-operation discards all in-flight tags; later fpu_result_i values produce no responses.

Configuration
REQ-035 Macro FPU_SCHED_OPCHECK_EN: when defined, an op code with op[1:0] = 00 is accepted, not issued (fpu_valid_o stays 0), and its tag carries err = 1, so the response at t+2+LAT has rsp_err_o = 1, rsp_result_o = 0, rsp_flags_o = 5'b10000 (NV).
REQ-036 Without FPU_SCHED_OPCHECK_EN, every accepted op is issued unchanged and rsp_err_o is tied to 0.

Structure
REQ-037 A shared package holds the 4-bit op-code field positions, the FSM state enum, the tag struct and the flag bit indices.
REQ-038 The round-robin arbiter is a separate sub-module, rr_arbiter (NREQ request in, one-hot grant out, pointer update on an accept input).

Verification
REQ-039 Reset, single request: req0 valid with op=0011, a=1.0, b=2.0, c=0.5 at cycle 0 -> fpu_valid_o at cycle 1; rsp_valid_o=01 at cycle 5 (LAT=3) carrying the model FPU result 2.5.
REQ-040 Fairness: both requesters held valid for 6 cycles -> grants alternate 0,1,0,1,0,1, and the responses return in the same order.
REQ-041 Flush: 3 ops in flight, flush_i at cycle k -> no rsp_valid_o for those ops; req_ready_o = 0 for cycles k..k+LAT+1; idle_o = 1 afterwards.
REQ-042 Same-cycle flush and valid -> no grant, no issue, no response.
REQ-043 With FPU_SCHED_OPCHECK_EN, op=0000 from req1 -> no fpu_valid_o; rsp_valid_o=10 at t+2+LAT with err=1, flags=10000.
REQ-044 rst_n pulsed low mid-stream -> all outputs 0 immediately; stale FPU results are ignored.

Source files
------------

// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: shared op-code fields, FSM states, tag record and flag bit indices
package fpu_sched_pkg;
  localparam int OP_SUB = 3;
  localparam int OP_NEG = 2;
  localparam int OP_ADD = 1;
  localparam int OP_MUL = 0;
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;
  localparam int IDW = 3;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
    logic           err;
  } tag_t;
endpackage

// File: rtl/fpu_sched_arb.sv
// rr_arbiter: round-robin one-hot grant; a mask keeps only requesters above the last winner
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_accept,
  output logic [N-1:0] o_gnt
);
  logic [N-1:0] r_mask;
  logic [N-1:0] w_mreq;
  assign w_mreq = i_req & r_mask;
  // an empty masked set wraps the search back to requester 0
  assign o_gnt = |w_mreq ? w_mreq & (~w_mreq + N'(1)) : i_req & (~i_req + N'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_mask <= '1;
    else if (i_accept) r_mask <= ~(o_gnt | (o_gnt - N'(1)));
endmodule

// File: rtl/fpu_sched.sv
// fpu_sched: shares one fixed-latency FPU pipeline among NREQ requesters, with flush drain.
// Optional FPU_SCHED_OPCHECK_EN: ops with no add/mul are retired as NV errors without issue.
module fpu_sched
  import fpu_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int FW   = 23,
  parameter int EW   = 8,
  parameter int LAT  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ-1:0][EW+FW:0]   req_opa_i,
  input  logic [NREQ-1:0][EW+FW:0]   req_opb_i,
  input  logic [NREQ-1:0][EW+FW:0]   req_opc_i,
  input  logic [NREQ-1:0][3:0]       req_op_i,
  input  logic                       flush_i,
  output logic                       fpu_valid_o,
  output logic [EW+FW:0]             fpu_opa_o,
  output logic [EW+FW:0]             fpu_opb_o,
  output logic [EW+FW:0]             fpu_opc_o,
  output logic [3:0]                 fpu_op_o,
  input  logic [EW+FW:0]             fpu_result_i,
  input  logic [4:0]                 fpu_flags_i,
  output logic [NREQ-1:0]            rsp_valid_o,
  output logic [EW+FW:0]             rsp_result_o,
  output logic [4:0]                 rsp_flags_o,
  output logic                       rsp_err_o,
  output logic                       idle_o
);
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  tag_t r_tag [LAT+1];
  logic [LAT:0] w_v;
  logic [NREQ-1:0] w_gnt;
  logic w_hs, w_bad, w_rsp;
  logic [IDW-1:0] w_id;
  logic [EW+FW:0] w_opa, w_opb, w_opc;
  logic [3:0] w_op;
  logic r_fpu_valid, r_rsp_valid_any;
  logic [EW+FW:0] r_opa, r_opb, r_opc, r_rsp_result;
  logic [3:0] r_op;
  logic [NREQ-1:0] r_rsp_valid;
  logic [4:0] r_rsp_flags;
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (req_valid_i & {NREQ{r_state != S_DRAIN && !flush_i}}),
    .i_accept(w_hs),
    .o_gnt   (w_gnt)
  );
  assign req_ready_o = w_gnt;
  assign w_hs = |w_gnt;
  always_comb begin
    w_opa = '0;
    w_opb = '0;
    w_opc = '0;
    w_op = '0;
    w_id = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt[i]) begin
        w_opa = req_opa_i[i];
        w_opb = req_opb_i[i];
        w_opc = req_opc_i[i];
        w_op = req_op_i[i];
        w_id = IDW'(i);
      end
  end
  always_comb begin
    w_v = '0;
    for (int k = 0; k <= LAT; k++) w_v[k] = r_tag[k].v;
  end
  // RUN stays while anything will still be in flight after this edge
  always_comb begin
    w_next = r_state;
    if (flush_i) w_next = S_DRAIN;
    else if (r_state == S_IDLE) w_next = w_hs ? S_RUN : S_IDLE;
    else if (r_state == S_RUN) w_next = (w_hs || |w_v[LAT-1:0]) ? S_RUN : S_IDLE;
    else w_next = (r_cnt == 4'(LAT)) ? S_IDLE : S_DRAIN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (flush_i || r_state != S_DRAIN) ? '0 : r_cnt + 4'd1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k <= LAT; k++) r_tag[k] <= '0;
    end else if (flush_i) begin
      for (int k = 0; k <= LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= tag_t'{v: w_hs, id: w_id, err: w_bad};
      for (int k = 1; k <= LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_fpu_valid <= 1'b0;
      r_opa <= '0;
      r_opb <= '0;
      r_opc <= '0;
      r_op <= '0;
    end else begin
      r_fpu_valid <= w_hs && !w_bad;
      if (w_hs) begin
        r_opa <= w_opa;
        r_opb <= w_opb;
        r_opc <= w_opc;
        r_op <= w_op;
      end
    end
  assign w_rsp = r_tag[LAT].v && !flush_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_valid_any <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags <= '0;
    end else begin
      r_rsp_valid <= w_rsp ? NREQ'(1) << r_tag[LAT].id : '0;
      r_rsp_valid_any <= w_rsp;
      if (w_rsp) begin
        r_rsp_result <= r_tag[LAT].err ? '0 : fpu_result_i;
        r_rsp_flags <= r_tag[LAT].err ? 5'(1) << FLG_NV : fpu_flags_i;
      end
    end
`ifdef FPU_SCHED_OPCHECK_EN
  logic r_rsp_err;
  assign w_bad = !w_op[OP_ADD] && !w_op[OP_MUL];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rsp_err <= 1'b0;
    else if (w_rsp) r_rsp_err <= r_tag[LAT].err;
  assign rsp_err_o = r_rsp_err;
`else
  assign w_bad = 1'b0;
  assign rsp_err_o = 1'b0;
`endif
  assign fpu_valid_o = r_fpu_valid;
  assign fpu_opa_o = r_opa;
  assign fpu_opb_o = r_opb;
  assign fpu_opc_o = r_opc;
  assign fpu_op_o = r_op;
  assign rsp_valid_o = r_rsp_valid & {NREQ{r_rsp_valid_any}};
  assign rsp_result_o = r_rsp_result;
  assign rsp_flags_o = r_rsp_flags;
  assign idle_o = (r_state == S_IDLE) && !(|w_v);
endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: table-driven directed check of fpu_sched against a real-valued FPU model
module tb_fpu_sched;
  localparam int LAT = 3;
  logic clk, rst_n, flush_i;
  logic [1:0] req_valid_i, req_ready_o, rsp_valid_o;
  logic [1:0][31:0] req_opa_i, req_opb_i, req_opc_i;
  logic [1:0][3:0] req_op_i;
  logic fpu_valid_o, rsp_err_o, idle_o;
  logic [31:0] fpu_opa_o, fpu_opb_o, fpu_opc_o, fpu_result_i, rsp_result_o;
  logic [3:0] fpu_op_o;
  logic [4:0] fpu_flags_i, rsp_flags_o;
  int nchk = 0, nerr = 0;
  fpu_sched #(.NREQ(2), .FW(23), .EW(8), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opa_i(req_opa_i), .req_opb_i(req_opb_i), .req_opc_i(req_opc_i), .req_op_i(req_op_i),
    .flush_i(flush_i), .fpu_valid_o(fpu_valid_o), .fpu_opa_o(fpu_opa_o), .fpu_opb_o(fpu_opb_o),
    .fpu_opc_o(fpu_opc_o), .fpu_op_o(fpu_op_o), .fpu_result_i(fpu_result_i),
    .fpu_flags_i(fpu_flags_i), .rsp_valid_o(rsp_valid_o), .rsp_result_o(rsp_result_o),
    .rsp_flags_o(rsp_flags_o), .rsp_err_o(rsp_err_o), .idle_o(idle_o)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e = 11'(x[30:23]) + 11'd896;
    if (x[30:0] == 0) return 0.0;
    return $bitstoreal({x[31], e, x[22:0], 29'b0});
  endfunction
  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d = $realtobits(r);
    logic [10:0] e = d[62:52] - 11'd896;
    if (d[62:0] == 0) return {d[63], 31'b0};
    return {d[63], e[7:0], d[51:29]};
  endfunction
  function automatic logic [31:0] fma(input logic [31:0] a, b, c, input logic [3:0] op);
    real r = op[0] ? sp2r(a) * sp2r(b) : sp2r(a);
    if (op[2]) r = -r;
    if (op[1]) r = op[3] ? r - sp2r(c) : r + sp2r(c);
    return r2sp(r);
  endfunction
  logic [31:0] p_res [LAT];
  logic [4:0] p_flg [LAT];
  always @(posedge clk) begin
    p_res[0] <= fpu_valid_o ? fma(fpu_opa_o, fpu_opb_o, fpu_opc_o, fpu_op_o) : 32'hDEADBEEF;
    p_flg[0] <= fpu_valid_o ? {1'b0, fpu_op_o} : 5'b11111;
    for (int k = 1; k < LAT; k++) begin
      p_res[k] <= p_res[k-1];
      p_flg[k] <= p_flg[k-1];
    end
  end
  assign fpu_result_i = p_res[LAT-1];
  assign fpu_flags_i = p_flg[LAT-1];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step(input logic [1:0] vld, input logic fl, input logic rs);
    @(posedge clk);
    #1 req_valid_i = vld;
    flush_i = fl;
    if (rs) begin
      rst_n = 0;
      #1 rst_n = 1;
    end
    @(negedge clk);
  endtask
  typedef struct packed {
    logic rs;
    logic [1:0] vld, rdy;
    logic fv;
    logic [1:0] rv;
    logic [31:0] res;
    logic idle;
  } vec_t;
  localparam logic [31:0] R25 = 32'h40200000, R7 = 32'h40E00000;
  vec_t tbl [18];
  initial begin
    tbl[0]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 32'h0, 1'b1};
    tbl[1]  = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b01, R25,   1'b1};
    tbl[6]  = '{1'b1, 2'b11, 2'b01, 1'b0, 2'b00, 32'h0, 1'b1};
    tbl[7]  = '{1'b0, 2'b11, 2'b10, 1'b1, 2'b00, 32'h0, 1'b0};
    tbl[8]  = '{1'b0, 2'b11, 2'b01, 1'b1, 2'b00, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 2'b11, 2'b10, 1'b1, 2'b00, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 2'b11, 2'b01, 1'b1, 2'b00, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 2'b11, 2'b10, 1'b1, 2'b01, R25,   1'b0};
    tbl[12] = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b10, R7,    1'b0};
    tbl[13] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b01, R25,   1'b0};
    tbl[14] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b10, R7,    1'b0};
    tbl[15] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b01, R25,   1'b0};
    tbl[16] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b10, R7,    1'b1};
    tbl[17] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0, 1'b1};
    rst_n = 0;
    flush_i = 0;
    req_valid_i = 0;
    req_opa_i[0] = 32'h3F800000; req_opb_i[0] = 32'h40000000; req_opc_i[0] = 32'h3F000000;
    req_opa_i[1] = 32'h40400000; req_opb_i[1] = 32'h40000000; req_opc_i[1] = 32'h3F800000;
    req_op_i[0] = 4'b0011;
    req_op_i[1] = 4'b0011;
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].vld, 1'b0, tbl[i].rs);
      chk($sformatf("row%0d ready", i), 32'(req_ready_o), 32'(tbl[i].rdy));
      chk($sformatf("row%0d fpu_valid", i), 32'(fpu_valid_o), 32'(tbl[i].fv));
      chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid_o), 32'(tbl[i].rv));
      chk($sformatf("row%0d idle", i), 32'(idle_o), 32'(tbl[i].idle));
      if (tbl[i].rv != 0) begin
        chk($sformatf("row%0d result", i), rsp_result_o, tbl[i].res);
        chk($sformatf("row%0d flags", i), 32'(rsp_flags_o), 32'h3);
        chk($sformatf("row%0d err", i), 32'(rsp_err_o), 32'h0);
      end
    end
    // op with neither add nor multiply from requester 1
    req_op_i[1] = 4'b0000;
    step(2'b10, 1'b0, 1'b0);
    chk("op0 ready", 32'(req_ready_o), 32'h2);
    step(2'b00, 1'b0, 1'b0);
`ifdef FPU_SCHED_OPCHECK_EN
    chk("op0 fpu_valid", 32'(fpu_valid_o), 32'h0);
`else
    chk("op0 fpu_valid", 32'(fpu_valid_o), 32'h1);
    chk("op0 fpu_op", 32'(fpu_op_o), 32'h0);
    chk("op0 fpu_opa", fpu_opa_o, 32'h40400000);
`endif
    req_op_i[1] = 4'b0011;
    repeat (3) step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    chk("op0 rsp_valid", 32'(rsp_valid_o), 32'h2);
`ifdef FPU_SCHED_OPCHECK_EN
    chk("op0 err", 32'(rsp_err_o), 32'h1);
    chk("op0 result", rsp_result_o, 32'h0);
    chk("op0 flags", 32'(rsp_flags_o), 32'h10);
`else
    chk("op0 err", 32'(rsp_err_o), 32'h0);
    chk("op0 result", rsp_result_o, 32'h40400000);
    chk("op0 flags", 32'(rsp_flags_o), 32'h0);
`endif
    // asynchronous reset with two ops in flight
    step(2'b01, 1'b0, 1'b0);
    chk("rst ready0", 32'(req_ready_o), 32'h1);
    step(2'b10, 1'b0, 1'b0);
    chk("rst ready1", 32'(req_ready_o), 32'h2);
    step(2'b00, 1'b0, 1'b0);
    #1 rst_n = 0;
    #1;
    chk("rst fpu_valid", 32'(fpu_valid_o), 32'h0);
    chk("rst fpu_opa", fpu_opa_o, 32'h0);
    chk("rst rsp_flags", 32'(rsp_flags_o), 32'h0);
    chk("rst rsp_result", rsp_result_o, 32'h0);
    chk("rst idle", 32'(idle_o), 32'h1);
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      step(2'b00, 1'b0, 1'b0);
      chk($sformatf("rst stale%0d", i), 32'(rsp_valid_o), 32'h0);
    end
    // flush with three ops in flight
    step(2'b01, 1'b0, 1'b0);
    chk("fl grant0", 32'(req_ready_o), 32'h1);
    step(2'b10, 1'b0, 1'b0);
    chk("fl grant1", 32'(req_ready_o), 32'h2);
    step(2'b01, 1'b0, 1'b0);
    chk("fl grant2", 32'(req_ready_o), 32'h1);
    step(2'b11, 1'b1, 1'b0);
    chk("fl ready k", 32'(req_ready_o), 32'h0);
    for (int i = 1; i <= LAT + 1; i++) begin
      step(2'b11, 1'b0, 1'b0);
      chk($sformatf("fl ready k+%0d", i), 32'(req_ready_o), 32'h0);
      chk($sformatf("fl rsp k+%0d", i), 32'(rsp_valid_o), 32'h0);
    end
    step(2'b00, 1'b0, 1'b0);
    chk("fl idle", 32'(idle_o), 32'h1);
    chk("fl rsp after", 32'(rsp_valid_o), 32'h0);
    step(2'b01, 1'b0, 1'b0);
    chk("fl regrant", 32'(req_ready_o), 32'h1);
    repeat (4) step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    chk("fl post rsp", 32'(rsp_valid_o), 32'h1);
    chk("fl post result", rsp_result_o, R25);
    // flush and valid in the same cycle
    step(2'b01, 1'b1, 1'b0);
    chk("sf ready", 32'(req_ready_o), 32'h0);
    step(2'b00, 1'b0, 1'b0);
    chk("sf fpu_valid", 32'(fpu_valid_o), 32'h0);
    for (int i = 2; i <= 7; i++) begin
      step(2'b00, 1'b0, 1'b0);
      chk($sformatf("sf rsp%0d", i), 32'(rsp_valid_o), 32'h0);
    end
    chk("sf idle", 32'(idle_o), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
